// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package : fir_pkg
// Brief   : Shared helpers for fir_param: ceil-log2, accumulator width
//           derivation and signed saturation limits.
// Rev     : 1.0  initial release
// ============================================================================
package fir_pkg;

  // Ceiling log2, never less than 1 so a port width is always legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Accumulator wide enough that summing n_taps full-scale products never wraps.
  function automatic int acc_width(input int din_w, input int coef_w, input int n_taps);
    return din_w + coef_w + clog2(n_taps);
  endfunction

  // Largest value representable in a signed field of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_scale.sv
`default_nettype none
// ============================================================================
// Module : fir_scale
// Brief  : Combinational round-half-up right shift followed by signed
//          saturation from the accumulator width to the output width.
// Rev    : 1.0  initial release
// ============================================================================
module fir_scale
  import fir_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int DOUT_W = 8,
  parameter int SHIFT  = 7
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     ovf
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(DOUT_W));
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(DOUT_W));

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] scaled;

  assign ext = EXT_W'(acc);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
      // Adding half an LSB then flooring rounds ties toward +infinity.
      assign scaled = (ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign scaled = ext;
    end
  endgenerate

  // Clamp to the output range and flag when the clamp engages.
  always_comb begin
    ovf  = 1'b0;
    dout = scaled[DOUT_W-1:0];
    if (scaled > MAX_V) begin
      dout = MAX_V[DOUT_W-1:0];
      ovf  = 1'b1;
    end else if (scaled < MIN_V) begin
      dout = MIN_V[DOUT_W-1:0];
      ovf  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_param.sv
`default_nettype none
// ============================================================================
// Module : fir_param
// Brief  : Parametrised pipelined signed direct-form FIR with writable
//          coefficient bank, full-precision sum, rounding, saturation and
//          synchronous flush. Latency 3 cycles from the accept edge.
// Rev    : 1.0  initial release
// ============================================================================
module fir_param
  import fir_pkg::*;
#(
  parameter int N_TAPS = 11,
  parameter int DIN_W  = 8,
  parameter int COEF_W = 8,
  parameter int DOUT_W = 8,
  parameter int SHIFT  = 7
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SCLR,
  input  logic signed [DIN_W-1:0]     DIN,
  input  logic                        VIN,
  input  logic                        COEF_WE,
  input  logic [clog2(N_TAPS)-1:0]    COEF_ADDR,
  input  logic signed [COEF_W-1:0]    COEF_DATA,
  output logic signed [DOUT_W-1:0]    DOUT,
  output logic                        VOUT,
  output logic                        OVF
);

  localparam int ADDR_W = clog2(N_TAPS);
  localparam int PROD_W = DIN_W + COEF_W;
  localparam int ACC_W  = acc_width(DIN_W, COEF_W, N_TAPS);

  logic signed [COEF_W-1:0] coef [N_TAPS];
  logic signed [DIN_W-1:0]  taps [N_TAPS];
  logic signed [PROD_W-1:0] prod [N_TAPS];
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc;
  logic [2:0]               vld;
  logic signed [DOUT_W-1:0] scaled_dout;
  logic                     scaled_ovf;

  // Coefficient bank; out-of-range addresses match no tap and are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_TAPS; k++) coef[k] <= '0;
    end else if (COEF_WE) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (COEF_ADDR == ADDR_W'(k)) coef[k] <= COEF_DATA;
      end
    end
  end

  // Sample delay line, advanced only by accepted samples.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || SCLR) begin
      for (int k = 0; k < N_TAPS; k++) taps[k] <= '0;
    end else if (VIN) begin
      taps[0] <= DIN;
      for (int k = 1; k < N_TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  // Stage 1: register every tap product from the post-accept taps and coefficients.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || SCLR) begin
      for (int k = 0; k < N_TAPS; k++) prod[k] <= '0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) prod[k] <= PROD_W'(taps[k]) * PROD_W'(coef[k]);
    end
  end

  // Full-precision adder across all products.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_TAPS; k++) sum = sum + ACC_W'(prod[k]);
  end

  // Stage 2: register the sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || SCLR) acc <= '0;
    else             acc <= sum;
  end

  // Valid shift register tracking accept -> products -> sum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || SCLR) vld <= '0;
    else             vld <= {vld[1:0], VIN};
  end

  fir_scale #(
    .ACC_W  (ACC_W),
    .DOUT_W (DOUT_W),
    .SHIFT  (SHIFT)
  ) u_scale (
    .acc  (acc),
    .dout (scaled_dout),
    .ovf  (scaled_ovf)
  );

  // Stage 3: output register; data and flag hold between valid results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || SCLR) begin
      DOUT <= '0;
      OVF  <= 1'b0;
      VOUT <= 1'b0;
    end else begin
      VOUT <= vld[2];
      if (vld[2]) begin
        DOUT <= scaled_dout;
        OVF  <= scaled_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_param.sv
`default_nettype none
// ============================================================================
// Module : tb_fir_param
// Brief  : Scoreboard bench for fir_param. Instance 0 uses SHIFT=0, instance 1
//          uses SHIFT=7; each has its own stimulus bus and expected queue.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              vin   [2];
  logic              sclr  [2];
  logic              we    [2];
  logic signed [7:0] din   [2];
  logic [3:0]        addr  [2];
  logic signed [7:0] cdata [2];

  logic signed [7:0] dout0, dout1;
  logic              vout0, vout1, ovf0, ovf1;

  fir_param #(.N_TAPS(11), .DIN_W(8), .COEF_W(8), .DOUT_W(8), .SHIFT(0)) u_dut0 (
    .CLK(clk), .RST(rst), .SCLR(sclr[0]), .DIN(din[0]), .VIN(vin[0]),
    .COEF_WE(we[0]), .COEF_ADDR(addr[0]), .COEF_DATA(cdata[0]),
    .DOUT(dout0), .VOUT(vout0), .OVF(ovf0)
  );

  fir_param #(.N_TAPS(11), .DIN_W(8), .COEF_W(8), .DOUT_W(8), .SHIFT(7)) u_dut1 (
    .CLK(clk), .RST(rst), .SCLR(sclr[1]), .DIN(din[1]), .VIN(vin[1]),
    .COEF_WE(we[1]), .COEF_ADDR(addr[1]), .COEF_DATA(cdata[1]),
    .DOUT(dout1), .VOUT(vout1), .OVF(ovf1)
  );

  typedef struct {
    int d;
    bit o;
    int a;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   sel   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Pop the entry due this cycle (accept edge + 3) and compare against the DUT.
  task automatic mon(input int i, input logic v, input logic signed [7:0] d, input logic o);
    exp_t e;
    bit   due;
    due = 1'b0;
    e   = '{d: 0, o: 1'b0, a: 0};
    if (i == 0 && q0.size() > 0 && q0[0].a + 3 <= cyc) begin
      e = q0.pop_front();
      due = 1'b1;
    end
    if (i == 1 && q1.size() > 0 && q1[0].a + 3 <= cyc) begin
      e = q1.pop_front();
      due = 1'b1;
    end
    if (due || v) begin
      check($sformatf("vout_dut%0d", i), int'(v), int'(due));
      if (due && v) begin
        check($sformatf("dout_dut%0d", i), d, e.d);
        check($sformatf("ovf_dut%0d", i), int'(o), int'(e.o));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, vout0, dout0, ovf0);
      mon(1, vout1, dout1, ovf1);
    end
  end

  // One cycle of stimulus on the selected instance; the other one idles.
  task automatic drive(input bit v, input int d, input bit w, input int a, input int cd, input bit sc);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0; sclr[i] = 1'b0; we[i] = 1'b0;
      din[i] = '0; addr[i] = '0; cdata[i] = '0;
    end
    vin[sel]   = v;
    din[sel]   = d[7:0];
    we[sel]    = w;
    addr[sel]  = a[3:0];
    cdata[sel] = cd[7:0];
    sclr[sel]  = sc;
  endtask

  task automatic push(input int d, input bit o);
    exp_t e;
    e = '{d: d, o: o, a: cyc + 1};
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic send(input int d, input int exp_d, input bit exp_o);
    drive(1'b1, d, 1'b0, 0, 0, 1'b0);
    push(exp_d, exp_o);
  endtask

  task automatic gap(input int d);
    drive(1'b0, d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int cd);
    drive(1'b0, 0, 1'b1, a, cd, 1'b0);
  endtask

  // SCLR, optionally with a coincident sample that must be dropped.
  task automatic flush(input bit v, input int d);
    drive(v, d, 1'b0, 0, 0, 1'b1);
    if (sel == 0) q0.delete();
    else          q1.delete();
  endtask

  initial begin
    #100us;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 1'b0; sclr[i] = 1'b0; we[i] = 1'b0;
      din[i] = '0; addr[i] = '0; cdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout0", dout0, 0);
    check("rst_vout0", int'(vout0), 0);
    check("rst_ovf0",  int'(ovf0), 0);
    check("rst_dout1", dout1, 0);
    check("rst_vout1", int'(vout1), 0);
    check("rst_ovf1",  int'(ovf1), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // ---------------- instance 0, SHIFT = 0 ----------------
    sel = 0;
    for (int k = 0; k < 11; k++) wr(k, k + 1);
    for (int a = 11; a < 16; a++) wr(a, 100);
    // Impulse: 1, 2, ..., 11 then 0
    send(1, 1, 1'b0);
    for (int n = 1; n < 12; n++) send(0, (n <= 10) ? n + 1 : 0, 1'b0);
    idle(4);

    // Gapped input, samples 1,2,3,1 with garbage on idle cycles
    flush(1'b0, 0);
    send(1, 1, 1'b0);
    gap(50);
    gap(50);
    send(2, 4, 1'b0);
    send(3, 10, 1'b0);
    gap(50);
    send(1, 17, 1'b0);
    idle(4);

    // Coefficient write on the accepting edge
    for (int k = 1; k < 11; k++) wr(k, 0);
    wr(0, 1);
    flush(1'b0, 0);
    send(5, 5, 1'b0);
    drive(1'b1, 5, 1'b1, 0, 2, 1'b0);
    push(10, 1'b0);
    send(4, 8, 1'b0);
    idle(4);

    // Flush with samples in flight and a coincident sample
    wr(1, 1);
    drive(1'b1, 7, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 7, 1'b0, 0, 0, 1'b0);
    flush(1'b1, 7);
    idle(5);
    check("sclr_dout0", dout0, 0);
    check("sclr_ovf0", int'(ovf0), 0);
    send(3, 6, 1'b0);
    send(4, 11, 1'b0);
    idle(4);

    // ---------------- instance 1, SHIFT = 7 ----------------
    sel = 1;
    for (int k = 0; k < 11; k++) wr(k, 127);
    flush(1'b0, 0);
    send(127, 126, 1'b0);
    for (int n = 1; n < 11; n++) send(127, 127, 1'b1);
    idle(4);
    flush(1'b0, 0);
    send(-128, -127, 1'b0);
    for (int n = 1; n < 11; n++) send(-128, -128, 1'b1);
    idle(4);

    // Rounding, b0 = 64 only
    wr(0, 64);
    for (int k = 1; k < 11; k++) wr(k, 0);
    send(3, 2, 1'b0);
    send(-3, -1, 1'b0);
    send(-1, 0, 1'b0);
    send(1, 1, 1'b0);
    idle(4);

    // ---------------- asynchronous reset mid-stream ----------------
    sel = 0;
    drive(1'b1, 3, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 4, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) vin[i] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_dout0", dout0, 0);
    check("arst_vout0", int'(vout0), 0);
    check("arst_ovf0",  int'(ovf0), 0);
    check("arst_dout1", dout1, 0);
    check("arst_ovf1",  int'(ovf1), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    send(9, 0, 1'b0);
    sel = 1;
    send(9, 0, 1'b0);
    idle(6);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_param.md
# fir_param

Parametrised, pipelined, signed direct-form FIR filter. It is the configurable successor to the fixed 11-tap, 8-bit `myfir` and drops into the same `clk_gen` / `data_maker` / `data_sink` bench environment. It adds the following on top of `myfir`:
- runtime-writable coefficient bank;
- full-precision accumulation;
- round-half-up scaling with saturation and an overflow flag;
- synchronous flush.

## Interface
Parameters:
- `N_TAPS`, default 11: number of taps; must be ≥ 2.
- `DIN_W`, default 8: input sample width, signed two's complement.
- `COEF_W`, default 8: coefficient width, signed.
- `DOUT_W`, default 8: output width, signed.
- `SHIFT`, default 7: right shift applied to the accumulator before output; 0 means no rounding is applied.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1: clock, rising-edge.
- `RST`  in  1: asynchronous active-high reset.
- `SCLR`  in  1: synchronous flush of data and valid state.
- `DIN`  in  `DIN_W`: input sample.
- `VIN`  in  1: `DIN` is valid; the sample is accepted at this edge.
- `COEF_WE`  in  1: coefficient write enable.
- `COEF_ADDR`  in  `clog2(N_TAPS)`: tap index to write, 0 = b0.
- `COEF_DATA`  in  `COEF_W`: coefficient value.
- `DOUT`  out  `DOUT_W`: filtered sample.
- `VOUT`  out  1: `DOUT` valid, one cycle per accepted input.
- `OVF`  out  1: the current `DOUT` was saturated; qualified by `VOUT`.

## Operation
- Transfer function: y[n] = Σ_{k=0}^{N_TAPS-1} b_k·x[n−k], where n counts accepted samples, not clock cycles.
- Delay line x[0..N_TAPS−1]:
  - shifts only on an edge where `VIN`=1 and `SCLR`=0;
  - the shift is x[0]←`DIN`, x[k]←x[k−1].
- Coefficient bank:
  - `COEF_WE`=1 writes `COEF_DATA` into b[`COEF_ADDR`];
  - `COEF_ADDR` ≥ `N_TAPS` is ignored, with no state change;
  - writes are unaffected by `SCLR`.
- Coefficient/sample ordering: a sample accepted at edge k uses the coefficient values held after edge k. A write on the same edge as an accept therefore applies to that sample.
- Arithmetic:
  - products are `DIN_W`+`COEF_W` bits;
  - the accumulator `ACC_W` = `DIN_W`+`COEF_W`+clog2(`N_TAPS`) bits, so it never wraps.
- Scaling:
  - if `SHIFT`>0: s = (acc + 2^(SHIFT−1)) >>> SHIFT, an arithmetic shift, i.e. round half toward +∞;
  - if `SHIFT`=0: s = acc.
- Saturation: s is clamped to [−2^(DOUT_W−1), 2^(DOUT_W−1)−1]. `OVF`=1 when the clamp is active.
- `SCLR`=1:
  - clears the delay line, the product registers and all valid bits;
  - a coincident `VIN` sample is dropped;
  - `VOUT` is 0 from the next cycle onward until new data emerges.
- `RST`: all registers, including coefficients, go to 0 immediately and asynchronously. Results of in-flight samples are lost and no `VOUT` is emitted for them.

## Timing
- Pipeline, for a sample accepted at edge k:
  - k+1: products registered, valid bit v1;
  - k+2: sum registered, v2;
  - k+3: scaled/saturated `DOUT`, `OVF`, `VOUT` registered.
- Latency is 3 cycles from the accept edge. `VOUT` is high for exactly one cycle per accepted sample.
- Throughput is 1 sample per cycle. There is no backpressure; the pipeline never stalls.
- With gaps in `VIN`, each output has the same 3-cycle latency; gaps are reproduced exactly on `VOUT`.
- `DOUT` and `OVF` hold their last values when `VOUT`=0. Both are 0 after `RST` or `SCLR`.
- Reset values: `DOUT`=0, `VOUT`=0, `OVF`=0.

## Structure
- Package `fir_pkg`:
  - `clog2` function;
  - `ACC_W` derivation;
  - signed min/max saturation constants as functions of width.
- Sub-module `fir_scale`: combinational round + saturate, `ACC_W` → `DOUT_W`, with an `OVF` output. It is instantiated once, ahead of the output register.
- The top level holds the coefficient bank, the delay line, the product registers, the adder (a pipelined tree is permitted only if the 3-cycle latency is kept) and the valid shift register.

## Test plan
- **Impulse response:** `SHIFT`=0, b_k = k+1 (1..11), `DIN` = 1 then zeros with `VIN`=1 continuously → `DOUT` = 1, 2, …, 11 then 0. The first `VOUT` carrying 1 appears 3 cycles after the impulse accept.
- **Saturation:** all b_k = 127, `SHIFT`=7, eleven samples of 127 → acc = 177419 → `DOUT`=127, `OVF`=1. Repeat with `DIN`=−128 → `DOUT`=−128, `OVF`=1.
- **Rounding:** b0 = 64, others 0, `SHIFT`=7:
  - `DIN`=3 → `DOUT`=2;
  - `DIN`=−3 → `DOUT`=−1;
  - `DIN`=1 → `DOUT`=1 (0.5 rounds up);
  - `OVF`=0 in all three cases.
- **Gapped input:** `VIN` pattern 1,0,0,1,1,0,1 with the impulse coefficients → the `VOUT` pattern is identical, shifted by 3 cycles. `DOUT` values match the model indexed by accepted samples.
- **Coefficient write during stream:** write b0 := 2 on the same edge as an accepted `DIN`=5 with `SHIFT`=0, other b_k = 0 → that output is 10; the preceding output uses the old b0.
- **Flush and reset:**
  - `SCLR` coincident with `VIN` → that sample is dropped, there is no `VOUT` for samples in flight, and coefficients are retained.
  - `RST` asserted mid-stream → `DOUT`/`VOUT`/`OVF` = 0 immediately, and b_k reads back as 0, so post-reset output is 0.
